// File: rtl/eth_rx_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module : eth_rx_hdr_parser
// Strips the 14-byte Ethernet header from the MAC RX halfword stream, presents
// dst/src MAC and EtherType as sideband, forwards payload, reports length/status.
// Rev    : 1.0
// ============================================================================
module eth_rx_hdr_parser #(
    parameter bit          ETYPE_FILTER_EN = 1'b0,
    parameter logic [15:0] ETYPE_0         = 16'h0800,
    parameter logic [15:0] ETYPE_1         = 16'h0806,
    parameter int          SIM_DELAY       = 1
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [23:0] s_axis_data,
    input  logic [1:0]  s_axis_keep,
    input  logic        s_axis_last,
    input  logic        s_axis_valid,
    output logic [47:0] hdr_dst_mac,
    output logic [47:0] hdr_src_mac,
    output logic [15:0] hdr_etype,
    output logic [7:0]  hdr_frame_no,
    output logic        hdr_valid,
    output logic [23:0] m_axis_data,
    output logic [1:0]  m_axis_keep,
    output logic        m_axis_last,
    output logic        m_axis_valid,
    output logic        frm_done,
    output logic        frm_err,
    output logic [10:0] frm_len
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HDR  = 2'd1,
        S_PLD  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    // Register timing is zero-delay here; SIM_DELAY is kept only for interface compatibility.
    if (SIM_DELAY < 0) begin : g_sim_delay_unused
    end

    state_t          r_state;
    logic [7:0]      r_frame_no;
    logic [2:0]      r_hcnt;
    logic [5:0][15:0] r_hw;
    logic [10:0]     r_len;

    logic [7:0]  w_fno;
    logic        w_restart;
    logic [15:0] w_etype;
    logic        w_etype_ok;
    logic [1:0]  w_pop;
    logic [11:0] w_sum;
    logic [10:0] w_len_next;

    function automatic logic [15:0] swap16(input logic [15:0] h);
        return {h[7:0], h[15:8]};
    endfunction

    assign w_fno      = s_axis_data[23:16];
    // A beat in IDLE, or any beat carrying a new frame number, starts a fresh header.
    assign w_restart  = s_axis_valid && ((r_state == S_IDLE) || (w_fno != r_frame_no));
    assign w_etype    = swap16(s_axis_data[15:0]);
    assign w_etype_ok = !ETYPE_FILTER_EN || (w_etype == ETYPE_0) || (w_etype == ETYPE_1);
    assign w_pop      = {1'b0, s_axis_keep[1]} + {1'b0, s_axis_keep[0]};
    assign w_sum      = {1'b0, r_len} + {10'd0, w_pop};
    assign w_len_next = w_sum[11] ? 11'h7FF : w_sum[10:0];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= S_IDLE;
            r_frame_no   <= '0;
            r_hcnt       <= '0;
            r_hw         <= '0;
            r_len        <= '0;
            hdr_dst_mac  <= '0;
            hdr_src_mac  <= '0;
            hdr_etype    <= '0;
            hdr_frame_no <= '0;
            hdr_valid    <= 1'b0;
            m_axis_data  <= '0;
            m_axis_keep  <= '0;
            m_axis_last  <= 1'b0;
            m_axis_valid <= 1'b0;
            frm_done     <= 1'b0;
            frm_err      <= 1'b0;
            frm_len      <= '0;
        end else begin
            hdr_valid    <= 1'b0;
            m_axis_valid <= 1'b0;
            m_axis_last  <= 1'b0;
            frm_done     <= 1'b0;
            frm_err      <= 1'b0;
            if (w_restart) begin
                if (r_state == S_PLD) begin
                    frm_done <= 1'b1;
                    frm_err  <= 1'b1;
                    frm_len  <= r_len;
                end
                r_frame_no <= w_fno;
                r_hw[0]    <= s_axis_data[15:0];
                r_hcnt     <= 3'd1;
                r_len      <= '0;
                r_state    <= s_axis_last ? S_IDLE : S_HDR;
            end else if (s_axis_valid) begin
                case (r_state)
                    S_HDR: begin
                        if (s_axis_last) begin
                            r_state <= S_IDLE;
                        end else if (r_hcnt == 3'd6) begin
                            if (w_etype_ok) begin
                                hdr_dst_mac  <= {swap16(r_hw[0]), swap16(r_hw[1]), swap16(r_hw[2])};
                                hdr_src_mac  <= {swap16(r_hw[3]), swap16(r_hw[4]), swap16(r_hw[5])};
                                hdr_etype    <= w_etype;
                                hdr_frame_no <= r_frame_no;
                                hdr_valid    <= 1'b1;
                                r_state      <= S_PLD;
                            end else begin
                                r_state <= S_DROP;
                            end
                        end else begin
                            r_hw[r_hcnt] <= s_axis_data[15:0];
                            r_hcnt       <= r_hcnt + 3'd1;
                        end
                    end
                    S_PLD: begin
                        m_axis_data  <= s_axis_data;
                        m_axis_keep  <= s_axis_keep;
                        m_axis_last  <= s_axis_last;
                        m_axis_valid <= 1'b1;
                        r_len        <= w_len_next;
                        if (s_axis_last) begin
                            frm_done <= 1'b1;
                            frm_len  <= w_len_next;
                            r_state  <= S_IDLE;
                        end
                    end
                    S_DROP: begin
                        if (s_axis_last) begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_eth_rx_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module : tb_eth_rx_hdr_parser
// Directed-vector bench for eth_rx_hdr_parser (EtherType filter enabled).
// Rev    : 1.0
// ============================================================================
module tb_eth_rx_hdr_parser;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic [23:0] s_axis_data = '0;
    logic [1:0]  s_axis_keep = '0;
    logic        s_axis_last = 1'b0;
    logic        s_axis_valid = 1'b0;
    logic [47:0] hdr_dst_mac, hdr_src_mac;
    logic [15:0] hdr_etype;
    logic [7:0]  hdr_frame_no;
    logic        hdr_valid;
    logic [23:0] m_axis_data;
    logic [1:0]  m_axis_keep;
    logic        m_axis_last, m_axis_valid;
    logic        frm_done, frm_err;
    logic [10:0] frm_len;

    eth_rx_hdr_parser #(
        .ETYPE_FILTER_EN (1'b1),
        .ETYPE_0         (16'h0800),
        .ETYPE_1         (16'h0806),
        .SIM_DELAY       (1)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .s_axis_data  (s_axis_data),
        .s_axis_keep  (s_axis_keep),
        .s_axis_last  (s_axis_last),
        .s_axis_valid (s_axis_valid),
        .hdr_dst_mac  (hdr_dst_mac),
        .hdr_src_mac  (hdr_src_mac),
        .hdr_etype    (hdr_etype),
        .hdr_frame_no (hdr_frame_no),
        .hdr_valid    (hdr_valid),
        .m_axis_data  (m_axis_data),
        .m_axis_keep  (m_axis_keep),
        .m_axis_last  (m_axis_last),
        .m_axis_valid (m_axis_valid),
        .frm_done     (frm_done),
        .frm_err      (frm_err),
        .frm_len      (frm_len)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [26:0] rx_q[$];
    logic [26:0] exp_q[$];
    logic [10:0] fd_len_q[$];
    logic        fd_err_q[$];
    int hv_cnt, ovl_cnt, fd_cnt, fd_nolast;

    always @(negedge aclk) begin
        if (hdr_valid) begin
            hv_cnt++;
            if (m_axis_valid) ovl_cnt++;
        end
        if (m_axis_valid) rx_q.push_back({m_axis_last, m_axis_keep, m_axis_data});
        if (frm_done) begin
            fd_cnt++;
            fd_len_q.push_back(frm_len);
            fd_err_q.push_back(frm_err);
            if (!frm_err && !(m_axis_valid && m_axis_last)) fd_nolast++;
        end
    end

    task automatic clear_mon();
        rx_q.delete(); exp_q.delete(); fd_len_q.delete(); fd_err_q.delete();
        hv_cnt = 0; ovl_cnt = 0; fd_cnt = 0; fd_nolast = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge aclk); #1; end
    endtask

    // Drives one frame of nbytes wire bytes; stops after max_beats beats (no last if truncated).
    task automatic send_frame(input logic [7:0] fno, input logic [47:0] dst, input logic [47:0] src,
                              input logic [15:0] et, input int nbytes, input int max_beats,
                              input bit fwd, input bit gaps);
        logic [7:0] b [0:2047];
        logic [7:0] lo, hi;
        logic [1:0] kp;
        logic       lst;
        int nbeats;
        for (int i = 0; i < 6; i++) begin
            b[i]     = dst[47 - 8*i -: 8];
            b[6 + i] = src[47 - 8*i -: 8];
        end
        b[12] = et[15:8];
        b[13] = et[7:0];
        for (int k = 14; k < nbytes; k++) b[k] = 8'((k * 7) + fno);
        nbeats = (nbytes + 1) / 2;
        for (int i = 0; i < nbeats && i < max_beats; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    s_axis_valid = 1'b0;
                    @(posedge aclk); #1;
                end
            end
            lo  = b[2*i];
            hi  = (2*i + 1 >= nbytes) ? 8'h00 : b[2*i + 1];
            kp  = (2*i + 1 >= nbytes) ? 2'b01 : 2'b11;
            lst = (i == nbeats - 1);
            s_axis_data  = {fno, hi, lo};
            s_axis_keep  = kp;
            s_axis_last  = lst;
            s_axis_valid = 1'b1;
            if (fwd && i >= 7) exp_q.push_back({lst, kp, fno, hi, lo});
            @(posedge aclk); #1;
        end
        s_axis_valid = 1'b0;
        s_axis_last  = 1'b0;
    endtask

    task automatic check_frame(input string tag, input int exp_hv, input logic [47:0] dst,
                               input logic [47:0] src, input logic [15:0] et, input logic [7:0] fno,
                               input int exp_fd, input logic [10:0] len, input logic [1:0] last_keep);
        check_eq({tag, "_hv_cnt"}, hv_cnt, exp_hv);
        if (exp_hv > 0) begin
            check_eq({tag, "_dst"}, hdr_dst_mac, dst);
            check_eq({tag, "_src"}, hdr_src_mac, src);
            check_eq({tag, "_etype"}, hdr_etype, et);
            check_eq({tag, "_fno"}, hdr_frame_no, fno);
        end
        check_eq({tag, "_beats"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++)
            check_eq({tag, "_pld"}, rx_q[i], exp_q[i]);
        check_eq({tag, "_fd_cnt"}, fd_cnt, exp_fd);
        if (exp_fd > 0 && fd_len_q.size() > 0) begin
            check_eq({tag, "_len"}, fd_len_q[$], len);
            check_eq({tag, "_err"}, fd_err_q[$], 1'b0);
            check_eq({tag, "_done_w_last"}, fd_nolast, 0);
        end
        if (rx_q.size() > 0) check_eq({tag, "_last_keep"}, rx_q[$][25:24], last_keep);
        check_eq({tag, "_overlap"}, ovl_cnt, 0);
    endtask

    localparam logic [47:0] c_bcast = 48'hFFFFFFFFFFFF;
    localparam logic [47:0] c_src   = 48'h000A35010203;
    localparam logic [47:0] c_dst2  = 48'h020406080A0C;

    initial begin
        clear_mon();
        #2 aresetn = 1'b0;
        idle(3);
        check_eq("rst_hdr_valid", hdr_valid, 1'b0);
        check_eq("rst_m_valid", m_axis_valid, 1'b0);
        check_eq("rst_frm_done", frm_done, 1'b0);
        check_eq("rst_dst", hdr_dst_mac, 48'h0);
        check_eq("rst_m_data", m_axis_data, 24'h0);
        check_eq("rst_len", frm_len, 11'h0);
        aresetn = 1'b1;
        idle(2);

        clear_mon();
        send_frame(8'd5, c_bcast, c_src, 16'h0800, 64, 1000, 1'b1, 1'b0);
        idle(5);
        check_eq("f64_beats_25", rx_q.size(), 25);
        check_frame("f64", 1, c_bcast, c_src, 16'h0800, 8'd5, 1, 11'd50, 2'b11);

        clear_mon();
        send_frame(8'd6, c_dst2, c_src, 16'h0806, 61, 1000, 1'b1, 1'b0);
        idle(5);
        check_eq("f61_beats_24", rx_q.size(), 24);
        check_frame("f61", 1, c_dst2, c_src, 16'h0806, 8'd6, 1, 11'd47, 2'b01);

        clear_mon();
        send_frame(8'd7, c_bcast, c_src, 16'h86DD, 64, 1000, 1'b0, 1'b0);
        idle(5);
        check_frame("filt", 0, '0, '0, '0, '0, 0, '0, '0);
        clear_mon();
        send_frame(8'd8, c_dst2, c_src, 16'h0806, 64, 1000, 1'b1, 1'b0);
        idle(5);
        check_frame("after_filt", 1, c_dst2, c_src, 16'h0806, 8'd8, 1, 11'd50, 2'b11);

        clear_mon();
        send_frame(8'd9, c_bcast, c_src, 16'h0800, 12, 1000, 1'b0, 1'b0);
        idle(5);
        check_frame("runt", 0, '0, '0, '0, '0, 0, '0, '0);
        clear_mon();
        send_frame(8'd10, c_bcast, c_src, 16'h0800, 64, 1000, 1'b1, 1'b0);
        idle(5);
        check_frame("after_runt", 1, c_bcast, c_src, 16'h0800, 8'd10, 1, 11'd50, 2'b11);

        clear_mon();
        send_frame(8'd3, c_bcast, c_src, 16'h0800, 64, 17, 1'b1, 1'b0);
        send_frame(8'd4, c_dst2, c_src, 16'h0806, 64, 1000, 1'b1, 1'b0);
        idle(5);
        check_eq("abort_fd_cnt", fd_cnt, 2);
        if (fd_len_q.size() >= 2) begin
            check_eq("abort_len", fd_len_q[0], 11'd20);
            check_eq("abort_err", fd_err_q[0], 1'b1);
            check_eq("abort_next_len", fd_len_q[1], 11'd50);
            check_eq("abort_next_err", fd_err_q[1], 1'b0);
        end
        check_eq("abort_beats_35", rx_q.size(), 35);
        check_frame("abort", 2, c_dst2, c_src, 16'h0806, 8'd4, 2, 11'd50, 2'b11);

        clear_mon();
        send_frame(8'd11, c_dst2, c_src, 16'h0800, 64, 1000, 1'b1, 1'b1);
        idle(5);
        check_frame("gaps", 1, c_dst2, c_src, 16'h0800, 8'd11, 1, 11'd50, 2'b11);

        clear_mon();
        send_frame(8'd12, c_bcast, c_src, 16'h0806, 64, 12, 1'b1, 1'b1);
        check_eq("pre_rst_m_valid", m_axis_valid, 1'b1);
        aresetn = 1'b0;
        #2;
        check_eq("async_rst_m_valid", m_axis_valid, 1'b0);
        check_eq("async_rst_dst", hdr_dst_mac, 48'h0);
        check_eq("async_rst_etype", hdr_etype, 16'h0);
        check_eq("async_rst_len", frm_len, 11'h0);
        idle(3);
        aresetn = 1'b1;
        idle(2);
        check_eq("rst_no_fd", fd_cnt, 0);
        clear_mon();
        send_frame(8'd13, c_dst2, c_src, 16'h0800, 61, 1000, 1'b1, 1'b0);
        idle(5);
        check_frame("after_rst", 1, c_dst2, c_src, 16'h0800, 8'd13, 1, 11'd47, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
